// File: rtl/cpu_ctrl.sv
// Control sequencer for the 8-register shared-bus CPU: latches an instruction in T0 and decodes bus selects and load enables in T1..T3.
// Build with CPU_MVNZ_EN defined to enable the conditional move (opcode 100); otherwise that opcode is an illegal no-op.
module cpu_ctrl #(
  parameter int DATA_W = 16,
  parameter int IR_W   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  input  logic              g_nz,
  output logic [7:0]        Rout_sel,
  output logic              din_sel,
  output logic              ALUout_sel,
  output logic [7:0]        Rin,
  output logic              Ain,
  output logic              Gin,
  output logic              addsub,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_e;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  state_e          state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;

  logic [2:0] op, rx, ry;
  logic [7:0] x_oh, y_oh;

  assign op   = ir_q[IR_W-1 -: 3];
  assign rx   = ir_q[5:3];
  assign ry   = ir_q[2:0];
  assign x_oh = 8'b1 << rx;
  assign y_oh = 8'b1 << ry;

  // Upper din bits only carry the mvi immediate, which goes straight onto the bus.
`ifdef CPU_MVNZ_EN
  logic unused_din;
  assign unused_din = ^din[DATA_W-1:IR_W];
`else
  logic unused_din;
  assign unused_din = ^{din[DATA_W-1:IR_W], g_nz, OP_MVNZ};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      T0: begin
        if (run) begin
          ir_d    = din[IR_W-1:0];
          state_d = T1;
        end
      end
      T1:      state_d = (op == OP_ADD || op == OP_SUB) ? T2 : T0;
      T2:      state_d = T3;
      default: state_d = T0;
    endcase
  end

  always_comb begin
    Rout_sel   = '0;
    din_sel    = 1'b0;
    ALUout_sel = 1'b0;
    Rin        = '0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    addsub     = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    if (!rst) begin
      busy = (state_q != T0);
      case (state_q)
        T1: begin
          case (op)
            OP_MV: begin
              Rout_sel = y_oh;
              Rin      = x_oh;
              done     = 1'b1;
            end
            OP_MVI: begin
              din_sel = 1'b1;
              Rin     = x_oh;
              done    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              Rout_sel = x_oh;
              Ain      = 1'b1;
            end
`ifdef CPU_MVNZ_EN
            OP_MVNZ: begin
              Rout_sel = y_oh;
              Rin      = g_nz ? x_oh : 8'h00;
              done     = 1'b1;
            end
`endif
            default: done = 1'b1;
          endcase
        end
        T2: begin
          Rout_sel = y_oh;
          Gin      = 1'b1;
          addsub   = (op == OP_SUB);
        end
        T3: begin
          ALUout_sel = 1'b1;
          Rin        = x_oh;
          done       = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: directed scenarios then random traffic against a queue-of-micro-ops reference model.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [15:0] din = '0;
  logic        g_nz = 1'b0;
  logic [7:0]  Rout_sel, Rin;
  logic        din_sel, ALUout_sel, Ain, Gin, addsub, done, busy;

  cpu_ctrl #(.DATA_W(16), .IR_W(9)) dut (
    .clk(clk), .rst(rst), .run(run), .din(din), .g_nz(g_nz),
    .Rout_sel(Rout_sel), .din_sel(din_sel), .ALUout_sel(ALUout_sel),
    .Rin(Rin), .Ain(Ain), .Gin(Gin), .addsub(addsub), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] rout;
    logic       dsel;
    logic       asel;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       done;
    logic       busy;
  } out_t;

  typedef struct packed {
    out_t out;
    logic cond;  // Rin only fires when g_nz is set
  } uop_t;

  uop_t uq[$];
  out_t last_vec;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic uop_t mk(input logic [7:0] rout, input logic dsel, input logic asel,
                              input logic [7:0] rin, input logic ain, input logic gin,
                              input logic sub, input logic dn, input logic cond);
    uop_t u;
    u.out  = '{rout: rout, dsel: dsel, asel: asel, rin: rin, ain: ain, gin: gin,
               addsub: sub, done: dn, busy: 1'b1};
    u.cond = cond;
    return u;
  endfunction

  // Expand an accepted instruction into the per-cycle bus activity it should produce.
  task automatic accept(input logic [8:0] ir);
    logic [2:0] op;
    logic [7:0] xo, yo;
    op = ir[8:6];
    xo = 8'h01 << ir[5:3];
    yo = 8'h01 << ir[2:0];
    case (op)
      3'd0: uq.push_back(mk(yo, 0, 0, xo, 0, 0, 0, 1, 0));
      3'd1: uq.push_back(mk(8'h00, 1, 0, xo, 0, 0, 0, 1, 0));
      3'd2, 3'd3: begin
        uq.push_back(mk(xo, 0, 0, 8'h00, 1, 0, 0, 0, 0));
        uq.push_back(mk(yo, 0, 0, 8'h00, 0, 1, op == 3'd3, 0, 0));
        uq.push_back(mk(8'h00, 0, 1, xo, 0, 0, 0, 1, 0));
      end
`ifdef CPU_MVNZ_EN
      3'd4: uq.push_back(mk(yo, 0, 0, xo, 0, 0, 0, 1, 1));
`endif
      default: uq.push_back(mk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0));
    endcase
  endtask

  task automatic step(input string tag, input logic r, input logic rn,
                      input logic [15:0] d, input logic gz);
    out_t exp, got;
    rst = r; run = rn; din = d; g_nz = gz;
    @(negedge clk);
    exp = '0;
    if (!r && uq.size() != 0) begin
      exp = uq[0].out;
      if (uq[0].cond && !gz) exp.rin = 8'h00;
    end
    got = '{rout: Rout_sel, dsel: din_sel, asel: ALUout_sel, rin: Rin, ain: Ain,
            gin: Gin, addsub: addsub, done: done, busy: busy};
    last_vec = got;
    chk(tag, 32'(got), 32'(exp));
    chk("bus_onehot", 32'($countones({Rout_sel, din_sel, ALUout_sel}) <= 1), 32'd1);
    chk("rin_onehot", 32'($countones(Rin) <= 1), 32'd1);
    @(posedge clk);
    if (r) uq.delete();
    else if (uq.size() != 0) void'(uq.pop_front());
    else if (rn) accept(d[8:0]);
    #1;
  endtask

  initial begin
    // Reset held with run asserted must not load anything.
    step("rst0", 1, 1, 16'o012, 0);
    step("rst1", 1, 1, 16'o012, 0);
    chk("ir_after_rst", 32'(dut.ir_q), 32'd0);
    step("idle", 0, 0, 16'o012, 0);

    // mv R1,R3
    step("mv_t0", 0, 1, 16'o013, 0);
    step("mv_t1", 0, 0, 16'h0000, 0);
    chk("mv_rout", 32'(last_vec.rout), 32'h08);
    chk("mv_rin", 32'(last_vec.rin), 32'h02);
    chk("mv_done", 32'(last_vec.done), 32'd1);
    step("mv_after", 0, 0, 16'h0000, 0);
    chk("mv_busy_after", 32'(last_vec.busy), 32'd0);

    // mvi R5,#AB
    step("mvi_t0", 0, 1, 16'o150, 0);
    step("mvi_t1", 0, 0, 16'h00AB, 0);
    chk("mvi_dsel", 32'(last_vec.dsel), 32'd1);
    chk("mvi_rin", 32'(last_vec.rin), 32'h20);

    // sub R2,R7
    step("sub_t0", 0, 1, 16'o327, 0);
    step("sub_t1", 0, 1, 16'h1FF, 0);
    chk("sub_t1_rout", 32'(last_vec.rout), 32'h04);
    step("sub_t2", 0, 1, 16'h1FF, 0);
    chk("sub_t2_rout", 32'(last_vec.rout), 32'h80);
    chk("sub_t2_addsub", 32'(last_vec.addsub), 32'd1);
    step("sub_t3", 0, 0, 16'h0000, 0);
    chk("sub_t3_rin", 32'(last_vec.rin), 32'h04);
    chk("sub_t3_asel", 32'(last_vec.asel), 32'd1);

    // Reset in T2 of add R0,R1, then rerun to completion
    step("ar_t0", 0, 1, 16'o201, 0);
    step("ar_t1", 0, 0, 16'h0000, 0);
    step("ar_rst", 1, 0, 16'h0000, 0);
    step("ar_idle", 0, 0, 16'h0000, 0);
    chk("ar_no_done", 32'(last_vec.done), 32'd0);
    step("add_t0", 0, 1, 16'o201, 0);
    step("add_t1", 0, 0, 16'h0000, 0);
    step("add_t2", 0, 0, 16'h0000, 0);
    chk("add_t2_addsub", 32'(last_vec.addsub), 32'd0);
    step("add_t3", 0, 0, 16'h0000, 0);
    chk("add_t3_rin", 32'(last_vec.rin), 32'h01);

    // mvnz R0,R1 with g_nz low then high
    step("mvnz0_t0", 0, 1, 16'o401, 0);
    step("mvnz0_t1", 0, 0, 16'h0000, 0);
    step("mvnz1_t0", 0, 1, 16'o401, 1);
    step("mvnz1_t1", 0, 0, 16'h0000, 1);
`ifdef CPU_MVNZ_EN
    chk("mvnz1_rin", 32'(last_vec.rin), 32'h01);
    chk("mvnz1_rout", 32'(last_vec.rout), 32'h02);
`else
    chk("mvnz1_rin", 32'(last_vec.rin), 32'h00);
    chk("mvnz1_done", 32'(last_vec.done), 32'd1);
`endif

    // Back-to-back with run held high
    for (int i = 0; i < 8; i++) step("b2b", 0, 1, 16'(9'o033 + i), 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), $urandom_range(0, 1),
           16'($urandom), $urandom_range(0, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
